// File: rtl/seizure_decision_if.sv
// Score stream between the per-channel weighted-sum serialiser and the
// seizure decision block.
//   sum_in    : signed channel score (SUM_W bits)
//   sum_valid : sum_in valid
//   sum_last  : final channel of the window, qualified by sum_valid
//   sum_ready : consumer can accept a score
// master = score source, slave = seizure_decision.
interface seizure_decision_if #(
  parameter int SUM_W = 12
);
  logic signed [SUM_W-1:0] sum_in;
  logic                    sum_valid;
  logic                    sum_last;
  logic                    sum_ready;

  modport master (output sum_in, output sum_valid, output sum_last, input  sum_ready);
  modport slave  (input  sum_in, input  sum_valid, input  sum_last, output sum_ready);
endinterface

// File: rtl/seizure_decision.sv
// Seizure decision: counts per-channel threshold hits in each analysis window,
// flags the window when enough channels vote, and raises seizure_det after
// PERSIST consecutive flagged windows.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : score stream sum_in/sum_valid/sum_last/sum_ready
//   win_valid    : one-cycle pulse, decision outputs updated
//   win_flag     : last window had vote_count >= VOTE_MIN
//   vote_count   : hits in last completed window
//   seizure_det  : detection level
//   err_len      : sticky, a window length differed from NUM_CH
//   ch_mask      : per-channel hit mask of last window
// Optional: define SEIZURE_DECISION_CHMASK_EN to build the ch_mask register;
// otherwise ch_mask is tied to 0.
module seizure_decision #(
  parameter int NUM_CH   = 16,
  parameter int SUM_W    = 12,
  parameter int THRESH   = 512,
  parameter int VOTE_MIN = 2,
  parameter int PERSIST  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  seizure_decision_if.slave           bus,
  output logic                        win_valid,
  output logic                        win_flag,
  output logic [$clog2(NUM_CH+1)-1:0] vote_count,
  output logic                        seizure_det,
  output logic                        err_len,
  output logic [NUM_CH-1:0]           ch_mask
);
  localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int VOTE_W = $clog2(NUM_CH+1);
  localparam int RUN_W  = $clog2(PERSIST+1);
  localparam logic [CNT_W-1:0]  LAST_CH = CNT_W'(NUM_CH-1);
  localparam logic [VOTE_W-1:0] VMIN    = VOTE_W'(VOTE_MIN);
  localparam logic [RUN_W-1:0]  PMAX    = RUN_W'(PERSIST);

  typedef enum logic {COLLECT, DECIDE} state_t;

  state_t             r_state;
  logic               r_ready;
  logic [CNT_W-1:0]   r_ch_cnt;
  logic [VOTE_W-1:0]  r_votes;
  logic [RUN_W-1:0]   r_run;
  logic               r_win_valid, r_win_flag, r_det, r_err;
  logic [VOTE_W-1:0]  r_vote_count;

  logic               w_accept, w_hit, w_at_last_ch, w_win_end, w_len_bad, w_flag;
  logic signed [31:0] w_score;
  logic [RUN_W-1:0]   w_run_next;

  // Score widened to 32 bits so THRESH is never truncated in the compare.
  assign w_score      = 32'(bus.sum_in);
  assign w_hit        = (w_score > THRESH);
  assign w_accept     = bus.sum_valid & r_ready;
  assign w_at_last_ch = (r_ch_cnt == LAST_CH);
  assign w_win_end    = bus.sum_last | w_at_last_ch;
  assign w_len_bad    = bus.sum_last ^ w_at_last_ch;
  assign w_flag       = (r_votes >= VMIN);
  assign w_run_next   = !w_flag ? '0 : (r_run >= PMAX) ? PMAX : r_run + 1'b1;

  // r_ready is only low in reset and in DECIDE, so it doubles as the
  // registered sum_ready.
  assign bus.sum_ready = r_ready;
  assign win_valid     = r_win_valid;
  assign win_flag      = r_win_flag;
  assign vote_count    = r_vote_count;
  assign seizure_det   = r_det;
  assign err_len       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= COLLECT;
      r_ready      <= 1'b0;
      r_ch_cnt     <= '0;
      r_votes      <= '0;
      r_run        <= '0;
      r_win_valid  <= 1'b0;
      r_win_flag   <= 1'b0;
      r_vote_count <= '0;
      r_det        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      case (r_state)
        COLLECT: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_votes  <= r_votes + VOTE_W'(w_hit);
            r_ch_cnt <= r_ch_cnt + 1'b1;
            if (w_win_end) begin
              r_state <= DECIDE;
              r_ready <= 1'b0;
              if (w_len_bad) r_err <= 1'b1;
            end
          end
        end
        DECIDE: begin
          r_win_valid  <= 1'b1;
          r_vote_count <= r_votes;
          r_win_flag   <= w_flag;
          r_run        <= w_run_next;
          r_det        <= (w_run_next >= PMAX);
          r_votes      <= '0;
          r_ch_cnt     <= '0;
          r_ready      <= 1'b1;
          r_state      <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

`ifdef SEIZURE_DECISION_CHMASK_EN
  logic [NUM_CH-1:0] r_mask, r_ch_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= '0;
      r_ch_mask <= '0;
    end else if (r_state == COLLECT) begin
      if (w_accept) r_mask[r_ch_cnt] <= w_hit;
    end else begin
      r_ch_mask <= r_mask;
      r_mask    <= '0;
    end
  end

  assign ch_mask = r_ch_mask;
`else
  assign ch_mask = '0;
`endif
endmodule

// File: tb/tb_seizure_decision.sv
module tb_seizure_decision;
  typedef logic signed [11:0] win_t [16];
  typedef struct {
    logic [4:0]  votes;
    logic        flag, det, err;
    logic [15:0] mask;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        win_valid, win_flag, seizure_det, err_len;
  logic [4:0]  vote_count;
  logic [15:0] ch_mask;

  seizure_decision_if #(.SUM_W(12)) bus ();

  seizure_decision #(.NUM_CH(16), .SUM_W(12), .THRESH(512), .VOTE_MIN(2), .PERSIST(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .win_valid(win_valid), .win_flag(win_flag), .vote_count(vote_count),
    .seizure_det(seizure_det), .err_len(err_len), .ch_mask(ch_mask)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc++;

  int   checks = 0, errors = 0;
  exp_t q[$];
  int   m_run = 0;
  bit   m_err = 0;
  int   first_acc, last_acc;
  bit   mon_en = 0;

  // Pops one expectation per win_valid pulse and checks pulse width.
  task automatic monitor();
    bit prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (win_valid) begin
          checks++;
          if (prev) begin errors++; $display("FAIL pulse_width win_valid high 2 cycles at cyc %0d", cyc); end
          if (q.size() == 0) begin
            errors++; $display("FAIL unexpected_win_valid at cyc %0d", cyc);
          end else begin
            e = q.pop_front();
            checks += 6;
            if (vote_count !== e.votes) begin errors++; $display("FAIL vote_count got %0d exp %0d", vote_count, e.votes); end
            if (win_flag !== e.flag) begin errors++; $display("FAIL win_flag got %b exp %b", win_flag, e.flag); end
            if (seizure_det !== e.det) begin errors++; $display("FAIL seizure_det got %b exp %b", seizure_det, e.det); end
            if (err_len !== e.err) begin errors++; $display("FAIL err_len got %b exp %b", err_len, e.err); end
            if (cyc !== e.cyc) begin errors++; $display("FAIL latency win_valid edge %0d exp %0d", cyc, e.cyc); end
`ifdef SEIZURE_DECISION_CHMASK_EN
            if (ch_mask !== e.mask) begin errors++; $display("FAIL ch_mask got %h exp %h", ch_mask, e.mask); end
`else
            if (ch_mask !== 16'h0) begin errors++; $display("FAIL ch_mask got %h exp 0000", ch_mask); end
`endif
          end
        end
        prev = win_valid;
      end else prev = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic signed [11:0] s, input bit last);
    int t;
    bus.sum_in = s; bus.sum_last = last; bus.sum_valid = 1'b1;
    t = 0;
    while (!bus.sum_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus.sum_ready) begin
      errors++;
      $display("FAIL ready_timeout sum_ready stuck 0 exp 1");
      bus.sum_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "ready timeout");
    end
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic send_window(input win_t sc, input int n, input bit keep);
    exp_t e;
    e.votes = '0; e.mask = '0;
    for (int i = 0; i < n; i++) if (sc[i] > 12'sd512) begin e.votes++; e.mask[i] = 1'b1; end
    e.flag = (e.votes >= 2);
    m_run  = e.flag ? ((m_run >= 3) ? 3 : m_run + 1) : 0;
    e.det  = (m_run >= 3);
    if (n != 16) m_err = 1;
    e.err  = m_err;
    for (int i = 0; i < n; i++) begin
      send_beat(sc[i], i == n - 1);
      if (i == 0) first_acc = last_acc;
    end
    e.cyc = last_acc + 1;
    q.push_back(e);
    if (!keep) begin bus.sum_valid = 1'b0; bus.sum_last = 1'b0; end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || win_valid) && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain_timeout pending %0d exp 0", q.size()); q.delete(); end
  endtask

  function automatic win_t hits(input logic [15:0] m);
    win_t w;
    for (int i = 0; i < 16; i++) w[i] = m[i] ? 12'sd1000 : 12'sd0;
    return w;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks += 2;
    if ({win_valid, win_flag, vote_count, seizure_det, err_len, ch_mask} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {win_valid, win_flag, vote_count, seizure_det, err_len, ch_mask});
    end
    if (bus.sum_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.sum_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sum_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", bus.sum_ready); end
  endtask

  task automatic test_basic();
    win_t w = hits(16'h0);
    w[0] = 12'sd513; w[1] = 12'sd600;
    send_window(w, 16, 0);
    wait_idle();
  endtask

  task automatic test_threshold();
    win_t w = hits(16'h0);
    w[3] = 12'sd512; w[4] = -12'sd7; w[5] = 12'sh800;
    send_window(w, 16, 0);
    wait_idle();
  endtask

  task automatic test_persist();
    send_window(hits(16'h8421), 16, 0);
    send_window(hits(16'hF000), 16, 0);
    send_window(hits(16'h0181), 16, 0);
    wait_idle();
    checks++;
    if (seizure_det !== 1'b1) begin errors++; $display("FAIL persist_det got %b exp 1", seizure_det); end
    send_window(hits(16'h0400), 16, 0);
    wait_idle();
    checks++;
    if (seizure_det !== 1'b0) begin errors++; $display("FAIL persist_fall got %b exp 0", seizure_det); end
  endtask

  task automatic test_short_window();
    send_window(hits(16'h0022), 6, 0);
    send_window(hits(16'h0300), 16, 0);
    send_window(hits(16'h0001), 16, 0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int f1, l1, f2;
    send_window(hits(16'h1111), 16, 1);
    f1 = first_acc; l1 = last_acc;
    send_window(hits(16'h00F0), 16, 0);
    f2 = first_acc;
    wait_idle();
    checks += 2;
    if (f2 - l1 !== 2) begin errors++; $display("FAIL b2b_bubble gap %0d exp 2", f2 - l1); end
    if (last_acc + 1 - f1 + 1 !== 34) begin errors++; $display("FAIL b2b_cycles got %0d exp 34", last_acc + 2 - f1); end
  endtask

  task automatic test_reset_mid();
    win_t w = hits(16'h3C00);
    send_window(hits(16'h0), 16, 0);
    send_window(hits(16'h0003), 16, 0);
    send_window(hits(16'h000C), 16, 0);
    wait_idle();
    for (int i = 0; i < 7; i++) send_beat(w[i], 1'b0);
    bus.sum_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if ({win_valid, win_flag, vote_count, seizure_det, err_len, ch_mask} !== '0) begin
      errors++; $display("FAIL async_reset_outputs got %h exp 0", {win_valid, win_flag, vote_count, seizure_det, err_len, ch_mask});
    end
    if (bus.sum_ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready got %b exp 0", bus.sum_ready); end
    m_run = 0; m_err = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_window(hits(16'h9009), 16, 0);
    wait_idle();
    checks++;
    if ({win_flag, seizure_det} !== 2'b10) begin errors++; $display("FAIL restart_run flag/det got %b exp 10", {win_flag, seizure_det}); end
  endtask

  initial begin
    bus.sum_in = '0; bus.sum_valid = 1'b0; bus.sum_last = 1'b0;
    fork monitor(); join_none
    mon_en = 1;
    test_reset();
    test_basic();
    test_threshold();
    test_persist();
    test_short_window();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
